// File: rtl/padd_pkg.sv
// Shared types and lane saturation constants for the packed saturating adder.
package padd_pkg;

   typedef enum logic [1:0] {
      SADD = 2'b00,
      SSUB = 2'b01,
      UADD = 2'b10,
      WADD = 2'b11
   } op_e;

   localparam int MAX_LANE_W = 8;

   // Signed bounds for a lane of the given width, zero-extended to MAX_LANE_W.
   function automatic logic [MAX_LANE_W-1:0] sat_max(input int lane_w);
      return MAX_LANE_W'((1 << (lane_w - 1)) - 1);
   endfunction

   function automatic logic [MAX_LANE_W-1:0] sat_min(input int lane_w);
      return MAX_LANE_W'(1 << (lane_w - 1));
   endfunction

endpackage

// File: rtl/padd_lane.sv
// One combinational lane: clamps a raw LANE_W+1-bit result according to the operation.
module padd_lane
   import padd_pkg::*;
#(
   parameter int LANE_W = 4
) (
   input  logic [LANE_W:0]   raw_i,
   input  op_e               op_i,
   output logic [LANE_W-1:0] res_o,
   output logic              sat_o
);

   localparam logic [MAX_LANE_W-1:0] SMAX = sat_max(LANE_W);
   localparam logic [MAX_LANE_W-1:0] SMIN = sat_min(LANE_W);

   // Signed overflow shows up as the extension bit disagreeing with the lane MSB.
   always_comb begin
      res_o = raw_i[LANE_W-1:0];
      sat_o = 1'b0;
      case (op_i)
         SADD, SSUB: begin
            if (raw_i[LANE_W] != raw_i[LANE_W-1]) begin
               sat_o = 1'b1;
               res_o = raw_i[LANE_W] ? SMIN[LANE_W-1:0] : SMAX[LANE_W-1:0];
            end
         end
         UADD: begin
            if (raw_i[LANE_W]) begin
               sat_o = 1'b1;
               res_o = '1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/padd_sat_pipe.sv
// Two-stage valid/ready pipeline: S1 holds raw per-lane results, S2 holds the
// saturated packed result and lane flags; a sticky register accumulates flags.
module padd_sat_pipe
   import padd_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int LANE_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        a,
   input  logic [DATA_W-1:0]        b,
   input  logic [1:0]               op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        sum,
   output logic [DATA_W/LANE_W-1:0] sat_mask,
   output logic [DATA_W/LANE_W-1:0] sat_sticky,
   input  logic                     clr_sticky
);

   localparam int LANES = DATA_W / LANE_W;

   if (DATA_W % LANE_W != 0) begin : g_bad_div
      $error("padd_sat_pipe: DATA_W must be a multiple of LANE_W");
   end
   if (LANE_W != 4 && LANE_W != 8) begin : g_bad_lane
      $error("padd_sat_pipe: LANE_W must be 4 or 8");
   end

   logic [2:1]                    vld_q;
   op_e                           s1_op_q;
   logic [LANES-1:0][LANE_W:0]    raw_d, s1_raw_q;
   logic [LANES-1:0][LANE_W-1:0]  sum_d, sum_q;
   logic [LANES-1:0]              mask_d, mask_q, sticky_d, sticky_q;
   logic                          s2_load, accept, fire;

   assign s2_load  = !vld_q[2] || out_ready;
   assign in_ready = !rst && (!vld_q[1] || s2_load);
   assign accept   = in_valid && in_ready;
   assign fire     = vld_q[2] && out_ready;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [LANE_W-1:0] la, lb;
      logic [LANE_W:0]   sa, sb;
      assign la = a[g*LANE_W +: LANE_W];
      assign lb = b[g*LANE_W +: LANE_W];
      assign sa = {la[LANE_W-1], la};
      assign sb = {lb[LANE_W-1], lb};
      // UADD and WADD share the zero-extended sum; only the clamp differs in S2.
      assign raw_d[g] = (op == SSUB) ? sa - sb :
                        (op == SADD) ? sa + sb :
                                       {1'b0, la} + {1'b0, lb};

      padd_lane #(.LANE_W(LANE_W)) u_lane (
         .raw_i (s1_raw_q[g]),
         .op_i  (s1_op_q),
         .res_o (sum_d[g]),
         .sat_o (mask_d[g])
      );
   end

   // Clear happens before the OR so a flag raised in the clearing cycle survives.
   always_comb begin
      sticky_d = sticky_q;
      if (clr_sticky) sticky_d = '0;
      if (fire)       sticky_d = sticky_d | mask_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q    <= '0;
         s1_op_q  <= SADD;
         s1_raw_q <= '0;
         sum_q    <= '0;
         mask_q   <= '0;
         sticky_q <= '0;
      end else begin
         if (in_ready) vld_q[1] <= in_valid;
         if (accept) begin
            s1_op_q  <= op_e'(op);
            s1_raw_q <= raw_d;
         end
         if (s2_load) vld_q[2] <= vld_q[1];
         if (s2_load && vld_q[1]) begin
            sum_q  <= sum_d;
            mask_q <= mask_d;
         end
         sticky_q <= sticky_d;
      end
   end

   assign out_valid  = vld_q[2];
   assign sum        = sum_q;
   assign sat_mask   = mask_q;
   assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_padd_sat_pipe.sv
// Scoreboard bench: stimulus pushes expected results, negedge monitors pop and compare.
module tb_padd_sat_pipe;
   import padd_pkg::*;

   logic        clk = 1'b0, rst = 1'b0;
   logic        in_valid = 1'b0, in_valid8 = 1'b0, out_ready = 1'b0, clr_sticky = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic [1:0]  op = '0;
   logic        in_ready, out_valid, in_ready8, out_valid8;
   logic [15:0] sum, sum8;
   logic [3:0]  sat_mask, sat_sticky;
   logic [1:0]  sat_mask8, sat_sticky8;

   typedef struct packed { logic [15:0] s; logic [3:0] m; } exp_t;
   exp_t q4[$], q8[$];
   exp_t e4, e8;
   int   n_checks = 0, n_fail = 0;
   int   inflight = 0;
   logic stall_q = 1'b0;
   logic [15:0] psum;
   logic [3:0]  pmask;
   bit   stream_done = 0;

   logic [15:0] st_a [8] = '{16'h1234, 16'h1234, 16'h1234, 16'hF0F0, 16'h0000, 16'h8888, 16'hFFFF, 16'h4321};
   logic [15:0] st_b [8] = '{16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h0001, 16'h4444};
   logic [1:0]  st_op[8] = '{WADD, UADD, SADD, UADD, SSUB, SSUB, WADD, SADD};
   logic [15:0] st_s [8] = '{16'h2345, 16'h2345, 16'h2345, 16'hF1F1, 16'hFFFF, 16'h8888, 16'hFFF0, 16'h7765};
   logic [3:0]  st_m [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b1111, 4'b0000, 4'b1000};
   logic [3:0]  pat = 4'b1001;

   always #5 clk = ~clk;

   padd_sat_pipe u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .sat_mask(sat_mask),
      .sat_sticky(sat_sticky), .clr_sticky(clr_sticky)
   );

   padd_sat_pipe #(.DATA_W(16), .LANE_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a), .b(b), .op(op),
      .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8), .sat_mask(sat_mask8),
      .sat_sticky(sat_sticky8), .clr_sticky(clr_sticky)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor for the 4-bit-lane instance: ordering, stall stability, in_ready rule.
   always @(negedge clk) begin
      if (rst) begin
         inflight = 0;
         stall_q  = 1'b0;
      end else begin
         chk("in_ready_rule", in_ready, !(inflight == 2 && !out_ready));
         if (stall_q) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_sum", sum, psum);
            chk("stall_mask", sat_mask, pmask);
         end
         if (out_valid && out_ready) begin
            if (q4.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_output: got %0h expected none", sum);
            end else begin
               e4 = q4.pop_front();
               chk("sum", sum, e4.s);
               chk("sat_mask", sat_mask, e4.m);
            end
         end
         inflight = inflight + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
         stall_q  = out_valid && !out_ready;
         psum     = sum;
         pmask    = sat_mask;
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid8 && out_ready) begin
         if (q8.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output8: got %0h expected none", sum8);
         end else begin
            e8 = q8.pop_front();
            chk("sum8", sum8, e8.s);
            chk("sat_mask8", sat_mask8, {30'b0, e8.m[1:0]});
         end
      end
   end

   // Called and returns at posedge+1; pushes the expectation once accepted.
   task automatic send(input bit w8, input logic [15:0] ta, input logic [15:0] tb,
                       input logic [1:0] top, input logic [15:0] es, input logic [3:0] em);
      bit acc = 0;
      a = ta; b = tb; op = top;
      if (w8) in_valid8 = 1'b1; else in_valid = 1'b1;
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk);
         acc = w8 ? in_ready8 : in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_valid8 = 1'b0;
      if (!acc) begin
         n_checks++; n_fail++;
         $display("FAIL accept_timeout: got no in_ready expected in_ready=1");
      end else if (w8) q8.push_back('{s: es, m: em});
      else q4.push_back('{s: es, m: em});
   endtask

   task automatic send_lat(input logic [15:0] ta, input logic [15:0] tb, input logic [1:0] top,
                           input logic [15:0] es, input logic [3:0] em);
      send(0, ta, tb, top, es, em);
      @(negedge clk);
      chk("lat_s1_only", out_valid, 0);
      @(negedge clk);
      chk("lat_out_valid", out_valid, 1);
      chk("lat_sum", sum, es);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int t = 0;
      while ((q4.size() != 0 || q8.size() != 0 || out_valid || out_valid8) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_done", (q4.size() == 0 && q8.size() == 0) ? 1 : 0, 1);
   endtask

   initial begin
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_mask", sat_mask, 0);
      chk("rst_sticky", sat_sticky, 0);
      chk("rst_in_ready", in_ready, 0);
      @(posedge clk); #1 rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", in_ready, 1);
      @(posedge clk); #1;

      send_lat(16'h760A, 16'hA6CD, SADD, 16'h17C8, 4'b0101);
      send(0, 16'hF78B, 16'hB87F, SADD, 16'hAFFA, 4'b0000);
      drain();
      chk("sticky_sadd", sat_sticky, 4'b0101);

      clr_sticky = 1'b1;
      @(posedge clk); #1 clr_sticky = 1'b0;
      chk("sticky_cleared", sat_sticky, 0);
      send(0, 16'h7000, 16'h8000, SSUB, 16'h7000, 4'b1000);
      send(0, 16'h9999, 16'h9999, UADD, 16'hFFFF, 4'b1111);
      send(0, 16'h9999, 16'h9999, WADD, 16'h2222, 4'b0000);
      drain();
      chk("sticky_ops", sat_sticky, 4'b1111);

      send(1, 16'h7F80, 16'h0180, SADD, 16'h7F80, 4'b0011);
      drain();
      chk("sticky8", sat_sticky8, 2'b11);

      clr_sticky = 1'b1;
      @(posedge clk); #1 clr_sticky = 1'b0;
      send(0, 16'h7800, 16'h8700, SSUB, 16'h7800, 4'b1100);
      drain();
      chk("sticky_pre_clr", sat_sticky, 4'b1100);
      out_ready = 1'b0;
      send(0, 16'h00F0, 16'h0010, UADD, 16'h00F0, 4'b0010);
      for (int t = 0; t < 20 && !out_valid; t++) begin
         @(posedge clk); #1;
      end
      chk("wait_valid", out_valid, 1);
      out_ready = 1'b1; clr_sticky = 1'b1;
      @(posedge clk); #1 clr_sticky = 1'b0;
      chk("sticky_clr_and_set", sat_sticky, 4'b0010);
      drain();

      fork
         begin
            for (int i = 0; i < 8; i++) send(0, st_a[i], st_b[i], st_op[i], st_s[i], st_m[i]);
            stream_done = 1;
         end
         begin
            int k = 0;
            while (!stream_done && k < 500) begin
               out_ready = pat[k % 4];
               @(posedge clk); #1;
               k++;
            end
         end
      join
      out_ready = 1'b1;
      drain();
      chk("sticky_stream", sat_sticky, 4'b1111);

      out_ready = 1'b0;
      send(0, 16'h760A, 16'hA6CD, SADD, 16'h17C8, 4'b0101);
      send(0, 16'h1234, 16'h1111, SADD, 16'h2345, 4'b0000);
      chk("full_out_valid", out_valid, 1);
      chk("full_in_ready", in_ready, 0);
      #2 rst = 1'b1;
      q4.delete();
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sum", sum, 0);
      chk("midrst_sticky", sat_sticky, 0);
      chk("midrst_mask", sat_mask, 0);
      chk("midrst_in_ready", in_ready, 0);
      @(posedge clk); #1 rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      send_lat(16'h1234, 16'h1111, WADD, 16'h2345, 4'b0000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
